// File: rtl/scratchpad_loader.sv
// Scratchpad loader: optionally zero-fills the scratchpad, streams an image into it while
// holding the core in reset, then releases the core and waits for a mailbox completion byte.
// Optional RUN watchdog enabled by defining SCRATCHPAD_LOADER_TIMEOUT_EN.
module scratchpad_loader #(
  parameter int          DATA_W         = 32,
  parameter int          DEPTH          = 4096,
  parameter int          MAILBOX_ADDR   = 0,
  parameter logic [7:0]  DONE_BYTE      = 8'hFF,
  parameter int          TIMEOUT_CYCLES = 1000000,
  localparam int         LANES          = DATA_W / 8,
  localparam int         ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_en,
  input  logic [ADDR_W:0]   word_count,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [LANES-1:0]  mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_reset,
  input  logic              mon_we,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [7:0]        mon_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic [2:0]        state_dbg
);

  // Image stream handshake: a beat transfers in any cycle where src_valid && src_ready are both
  // high at the rising clock edge; src_data must be stable while src_valid is high.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] MBOX      = ADDR_W'(MAILBOX_ADDR);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   BEAT_ONE  = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     beat_q, beat_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                timeout_q, timeout_d;
  logic                core_reset_q;
  logic                start_ok;
  logic                mailbox_hit;
  logic                tmo_expire;

  assign start_ok    = (word_count != '0) && (word_count <= MAX_COUNT);
  assign mailbox_hit = mon_we && (mon_addr == MBOX) && (mon_data == DONE_BYTE);

`ifdef SCRATCHPAD_LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_RELEASE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  // The Nth RUN cycle sees a count of N-1, so the watchdog fires during RUN cycle TIMEOUT_CYCLES.
  assign tmo_expire = (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: RUN waits for the mailbox forever; the parameter stays referenced.
  assign tmo_expire = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    count_d   = count_q;
    done_d    = done_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    src_ready = 1'b0;
    mem_we    = '0;
    mem_addr  = addr_q;
    mem_wdata = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (start_ok) begin
            count_d   = word_count;
            error_d   = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            addr_d    = '0;
            beat_d    = '0;
            state_d   = clear_en ? S_CLEAR : S_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        mem_we = '1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_LOAD;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_LOAD: begin
        src_ready = 1'b1;
        mem_wdata = src_data;
        if (src_valid) begin
          mem_we = '1;
          beat_d = beat_q + BEAT_ONE;
          // Holding the address on the final beat keeps it from wrapping past DEPTH-1.
          if ((beat_q + BEAT_ONE) == count_q) begin
            state_d = S_RELEASE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mailbox_hit) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (tmo_expire) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      count_q      <= count_d;
      done_q       <= done_d;
      error_q      <= error_d;
      timeout_q    <= timeout_d;
      // Core runs only in RUN and DONE; it falls on the edge entering RUN.
      core_reset_q <= !((state_d == S_RUN) || (state_d == S_DONE));
    end
  end

  assign core_reset = core_reset_q;
  assign busy       = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_RELEASE);
  assign done       = done_q;
  assign error      = error_q;
  assign timeout    = timeout_q;
  assign state_dbg  = state_q;

endmodule
